// File: rtl/jellyvl_etherneco_pkg.sv
// rtl/jellyvl_etherneco_pkg.sv - shared types and helpers for the etherneco sync timer slave
package jellyvl_etherneco_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } measure_state_t;

    localparam int DEFAULT_DELAY_BYTES = 4;
    typedef logic [8*DEFAULT_DELAY_BYTES-1:0] delay_t;

    localparam int OFFSET_WIDTH = 16;

    function automatic int slot_offset(input int header_bytes, input logic [7:0] node_id,
                                       input int delay_bytes);
        return header_bytes + int'({24'd0, node_id}) * delay_bytes;
    endfunction

endpackage

// File: rtl/jellyvl_etherneco_delay_measure.sv
// rtl/jellyvl_etherneco_delay_measure.sv - ring round-trip delay measurement with timeout
module jellyvl_etherneco_delay_measure
    import jellyvl_etherneco_pkg::*;
#(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int LATENCY_COMP   = 0
) (
    input  logic          reset,
    input  logic          clk,
    input  logic [DW-1:0] current_time,
    input  logic          start,
    input  logic          stop,
    output logic [DW-1:0] delay_time,
    output logic          delay_valid,
    output logic          delay_timeout
);

    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] COMP      = DW'(LATENCY_COMP);

    measure_state_t state, state_next;
    logic [DW-1:0]  start_time, start_time_next;
    logic [CW-1:0]  cnt, cnt_next, cnt_inc;
    logic [DW-1:0]  diff, comp_delay;
    logic [DW-1:0]  delay_time_next;
    logic           delay_valid_next;
    logic           delay_timeout_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            start_time    <= '0;
            cnt           <= '0;
            delay_time    <= '0;
            delay_valid   <= 1'b0;
            delay_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            start_time    <= start_time_next;
            cnt           <= cnt_next;
            delay_time    <= delay_time_next;
            delay_valid   <= delay_valid_next;
            delay_timeout <= delay_timeout_next;
        end
    end

    always_comb begin
        state_next         = state;
        start_time_next    = start_time;
        cnt_next           = cnt;
        delay_time_next    = delay_time;
        delay_valid_next   = delay_valid;
        delay_timeout_next = 1'b0;
        cnt_inc            = cnt + 1'b1;

        // Modulo subtraction makes a wrap of the free-running timer harmless
        diff       = current_time - start_time;
        comp_delay = (diff < COMP) ? '0 : (diff - COMP);

        case (state)
            ST_IDLE: begin
            end
            ST_MEASURE: begin
                if (stop) begin
                    delay_time_next  = comp_delay;
                    delay_valid_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        delay_timeout_next = 1'b1;
                        state_next         = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A new start always re-arms, after any stop in the same cycle was consumed
        if (start) begin
            start_time_next    = current_time;
            cnt_next           = '0;
            state_next         = ST_MEASURE;
            delay_timeout_next = 1'b0;
        end
    end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_slave_delay_insert.sv
// rtl/jellyvl_etherneco_synctimer_slave_delay_insert.sv - measures ring delay and writes it into this node's frame slot
module jellyvl_etherneco_synctimer_slave_delay_insert
    import jellyvl_etherneco_pkg::*;
#(
    parameter int TIMER_WIDTH    = 64,
    parameter int DELAY_BYTES    = 4,
    parameter int HEADER_BYTES   = 2,
    parameter int MAX_NODES      = 32,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int ACCUMULATE     = 0,
    parameter int LATENCY_COMP   = 0
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic [TIMER_WIDTH-1:0]   current_time,
    input  logic [7:0]               node_id,
    input  logic                     outer_rx_end,
    input  logic                     inner_rx_start,
    input  logic                     inner_rx_error,
    input  logic                     s_first,
    input  logic                     s_last,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     m_first,
    output logic                     m_last,
    output logic                     m_valid,
    output logic [7:0]               m_data,
    output logic [8*DELAY_BYTES-1:0] delay_time,
    output logic                     delay_valid,
    output logic                     delay_timeout
);

    localparam int DW = 8 * DELAY_BYTES;

    jellyvl_etherneco_delay_measure #(
        .DW             (DW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .LATENCY_COMP   (LATENCY_COMP)
    ) u_measure (
        .reset         (reset),
        .clk           (clk),
        .current_time  (current_time[DW-1:0]),
        .start         (outer_rx_end),
        .stop          (inner_rx_start),
        .delay_time    (delay_time),
        .delay_valid   (delay_valid),
        .delay_timeout (delay_timeout)
    );

    if (TIMER_WIDTH > DW) begin : g_time_upper
        logic unused_time_upper;
        assign unused_time_upper = ^current_time[TIMER_WIDTH-1:DW];
    end

    logic [OFFSET_WIDTH-1:0] offset;
    logic                    carry;
    logic                    err_flag;
    logic                    in_frame;
    logic [DW-1:0]           snap_delay;
    logic                    snap_valid;

    logic                    frame_start;
    logic [OFFSET_WIDTH-1:0] beat_off;
    logic [OFFSET_WIDTH-1:0] offset_next;
    logic [DW-1:0]           cur_delay;
    logic                    cur_valid;
    logic                    cur_err;
    logic                    cur_active;
    logic                    node_ok;
    int                      slot_base;
    int                      slot_pos;
    int                      slot_k;
    logic                    in_slot;
    logic                    edit;
    logic [7:0]              ins_byte;
    logic                    carry_in;
    logic [8:0]              sum;
    logic [7:0]              out_data;
    logic                    carry_next;

    // The first beat uses the live measurement, later beats use the snapshot taken then
    always_comb begin
        frame_start = s_valid & s_first;
        beat_off    = frame_start ? '0 : offset;
        offset_next = (beat_off == '1) ? beat_off : beat_off + 1'b1;
        cur_delay   = frame_start ? delay_time : snap_delay;
        cur_valid   = frame_start ? delay_valid : snap_valid;
        cur_err     = (frame_start ? 1'b0 : err_flag) | inner_rx_error;
        cur_active  = frame_start | in_frame;
        node_ok     = int'({24'd0, node_id}) < MAX_NODES;

        slot_base = slot_offset(HEADER_BYTES, node_id, DELAY_BYTES);
        slot_pos  = int'({16'd0, beat_off}) - slot_base;
        in_slot   = (slot_pos >= 0) && (slot_pos < DELAY_BYTES);
        slot_k    = in_slot ? slot_pos : 0;

        edit     = s_valid & cur_active & cur_valid & node_ok & ~cur_err & in_slot;
        ins_byte = 8'(cur_delay >> (8 * slot_k));
        carry_in = (slot_k == 0) ? 1'b0 : carry;
        sum      = {1'b0, s_data} + {1'b0, ins_byte} + {8'd0, carry_in};

        out_data   = s_data;
        carry_next = frame_start ? 1'b0 : carry;
        if (edit) begin
            if (ACCUMULATE != 0) begin
                out_data   = sum[7:0];
                carry_next = sum[8];
            end else begin
                out_data = ins_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            offset     <= '0;
            carry      <= 1'b0;
            err_flag   <= 1'b0;
            in_frame   <= 1'b0;
            snap_delay <= '0;
            snap_valid <= 1'b0;
        end else begin
            m_first <= s_first;
            m_last  <= s_last;
            m_valid <= s_valid;
            m_data  <= out_data;
            carry   <= carry_next;
            if (s_valid) begin
                offset   <= offset_next;
                in_frame <= cur_active & ~s_last;
            end
            if (frame_start) begin
                snap_delay <= delay_time;
                snap_valid <= delay_valid;
                err_flag   <= inner_rx_error;
            end else if (inner_rx_error) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule
